ahb_master_arbiter: RTL

- Round-robin arbiter that shares one AHB-Lite master controller among NUM_REQ requesters (e.g. the SPI bridge and local DMA/CPU ports).
- Samples each requester's transfer descriptor (write, burst, length) at grant time, issues a one-cycle start to the master controller, holds ownership until the controller's done pulse, then returns a per-requester completion pulse.
- Sits directly above the AHB master controller; owns its start/write/burst/burst_len inputs.

---
 rtl/ahb_master_arbiter_if.sv | 34 +++
 rtl/ahb_master_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the AHB master controller.
// master: arbiter view; slave: requester/controller view.
interface ahb_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OWN_W   = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_write;
  logic [3*NUM_REQ-1:0] req_burst;
  logic [4*NUM_REQ-1:0] req_len;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic [OWN_W-1:0]     owner;
  logic                 arb_busy;
  logic                 m_start;
  logic                 m_write;
  logic [2:0]           m_burst;
  logic [3:0]           m_burst_len;
  logic                 m_busy;
  logic                 m_done;

  modport master (
    input  req, req_write, req_burst, req_len, m_busy, m_done,
    output gnt, req_done, req_err, owner, arb_busy,
    output m_start, m_write, m_burst, m_burst_len
  );

  modport slave (
    output req, req_write, req_burst, req_len, m_busy, m_done,
    input  gnt, req_done, req_err, owner, arb_busy,
    input  m_start, m_write, m_burst, m_burst_len
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master controller among NUM_REQ requesters.
// Optional watchdog on an owned transfer: define ARB_TIMEOUT_EN.
module ahb_master_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned OWN_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_master_arbiter_if.master  bus
);

  typedef enum logic [1:0] {ArbIdle, ArbStart, ArbWait} arb_state_e;

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic [NUM_REQ-1:0]   req_err_q, req_err_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_owner_q, last_owner_d;
  logic                 arb_busy_q, arb_busy_d;
  logic                 m_start_q, m_start_d;
  logic                 m_write_q, m_write_d;
  logic [2:0]           m_burst_q, m_burst_d;
  logic [3:0]           m_burst_len_q, m_burst_len_d;

  logic                 req_any;
  logic [OWN_W-1:0]     sel;
  logic                 sel_write;
  logic [2:0]           sel_burst;
  logic [3:0]           sel_len;
  logic                 done_ok;
  logic                 timeout;
  logic                 release_own;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign req_any = |bus.req;

  // Scan last_owner+1 upward with wrap; the largest offset is written first so the nearest
  // requester wins and the previous owner ends up with lowest priority.
  always_comb begin
    logic [OWN_W:0] idx;
    sel = last_owner_q;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_owner_q} + (OWN_W + 1)'(k);
      if (idx >= (OWN_W + 1)'(NUM_REQ)) begin
        idx = idx - (OWN_W + 1)'(NUM_REQ);
      end
      if (bus.req[idx[OWN_W-1:0]]) begin
        sel = idx[OWN_W-1:0];
      end
    end
  end

  // Descriptor fields of the selected requester.
  always_comb begin
    sel_write = 1'b0;
    sel_burst = 3'd0;
    sel_len   = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == OWN_W'(i)) begin
        sel_write = bus.req_write[i];
        sel_burst = bus.req_burst[3*i +: 3];
        sel_len   = bus.req_len[4*i +: 4];
      end
    end
  end

  assign done_ok = (state_q == ArbWait) && bus.m_done;

`ifdef ARB_TIMEOUT_EN
  // A done pulse on the expiry edge wins: the transfer completed normally.
  assign timeout = (state_q != ArbIdle) && (cnt_q == CntLast) && !done_ok;
`else
  assign timeout = 1'b0;
`endif

  assign release_own = done_ok || timeout;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    req_done_d    = '0;
    req_err_d     = '0;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    arb_busy_d    = arb_busy_q;
    m_start_d     = 1'b0;
    m_write_d     = m_write_q;
    m_burst_d     = m_burst_q;
    m_burst_len_d = m_burst_len_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      ArbIdle: begin
        if (req_any && !bus.m_busy) begin
          state_d       = ArbStart;
          owner_d       = sel;
          arb_busy_d    = 1'b1;
          m_start_d     = 1'b1;
          m_write_d     = sel_write;
          m_burst_d     = sel_burst;
          m_burst_len_d = (sel_len == 4'd0) ? 4'd1 : sel_len;
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (sel == OWN_W'(i));
          end
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      ArbStart, ArbWait: begin
        if (state_q == ArbStart) begin
          state_d = ArbWait;
        end
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (release_own) begin
          state_d      = ArbIdle;
          gnt_d        = '0;
          arb_busy_d   = 1'b0;
          last_owner_d = owner_q;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_done_d[i] = (owner_q == OWN_W'(i));
            req_err_d[i]  = (owner_q == OWN_W'(i)) && timeout;
          end
        end
      end

      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ArbIdle;
      gnt_q         <= '0;
      req_done_q    <= '0;
      req_err_q     <= '0;
      owner_q       <= '0;
      last_owner_q  <= OWN_W'(NUM_REQ - 1);
      arb_busy_q    <= 1'b0;
      m_start_q     <= 1'b0;
      m_write_q     <= 1'b0;
      m_burst_q     <= 3'd0;
      m_burst_len_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      req_done_q    <= req_done_d;
      req_err_q     <= req_err_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      arb_busy_q    <= arb_busy_d;
      m_start_q     <= m_start_d;
      m_write_q     <= m_write_d;
      m_burst_q     <= m_burst_d;
      m_burst_len_q <= m_burst_len_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.gnt         = gnt_q;
  assign bus.req_done    = req_done_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.req_err     = req_err_q;
`else
  assign bus.req_err     = '0;
`endif
  assign bus.owner       = owner_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_burst     = m_burst_q;
  assign bus.m_burst_len = m_burst_len_q;

`ifndef ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] unused_req_err;
  assign unused_req_err = req_err_q;
`endif

endmodule
